out_en_alloc: RTL and testbench
===============================

OUT_EN_ALLOC -- requirements
Module: out_en_alloc

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 5, meaning the number of router ports; each port has one input side and one output side.
REQ-002 SHALL have parameter SEL_W, default 3, meaning the select-code width; it SHALL satisfy 2^SEL_W >= NUM_PORTS.
REQ-003 SHALL have parameter CREDITS, default 4, meaning the downstream buffer depth per output; valid range is 1..15.
REQ-004 SHALL use counter width CW = 4 bits for each credit counter.
REQ-005 Port clk  input  1  system clock; all state updates on rising edge.
REQ-006 Port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 Port sel  input  NUM_PORTS*SEL_W  per-output select code; slice o holds the input index routed to output o.
REQ-008 Port sel_vld  input  NUM_PORTS  per-output flag; 1 means sel slice o is meaningful this cycle.
REQ-009 Port push_o  input  NUM_PORTS  per-input flag; 1 means input i holds a flit ready to leave.
REQ-010 Port credit_ret  input  NUM_PORTS  per-output one-cycle pulse; downstream freed one slot.
REQ-011 Port out_en  output  NUM_PORTS  per-output write enable toward the downstream buffer.
REQ-012 Port in_pop  output  NUM_PORTS  per-input dequeue strobe for the input FIFO.
REQ-013 Port credit_cnt  output  NUM_PORTS*CW  current credit count per output.
REQ-014 Port err_ovf  output  NUM_PORTS  sticky per-output credit-overflow flag.

Function
REQ-015 Output o SHALL request input i when sel_vld[o]=1 and sel slice o = i; a select code >= NUM_PORTS SHALL request nothing.
REQ-016 Input i SHALL be eligible when push_o[i]=1, at least one output requests it, and every requesting output has credit_cnt > 0.
REQ-017 in_pop[i] SHALL be 1 exactly when input i is eligible; otherwise 0.
REQ-018 out_en[o] SHALL be 1 exactly when output o requests an eligible input; otherwise 0.
REQ-019 Multicast SHALL be atomic: if any requesting output of input i has zero credit, no output for input i is enabled and in_pop[i]=0.
REQ-020 out_en and in_pop SHALL be combinational from the current inputs and registered credit state, so zero-cycle latency applies; no grant is lost or duplicated.
REQ-021 Each credit counter SHALL update on rising clk: next = cnt - out_en[o] + credit_ret[o].
REQ-022 Simultaneous out_en[o]=1 and credit_ret[o]=1 SHALL leave the count unchanged.
REQ-023 A credit_ret[o] that would take the count above CREDITS SHALL be ignored, the count SHALL hold at CREDITS, and err_ovf[o] SHALL set.
REQ-024 Once set, err_ovf[o] SHALL stay 1 until reset.
REQ-025 The credit count SHALL never go below 0; REQ-016 guarantees this.

Reset
REQ-026 While reset=0: every credit_cnt = CREDITS, err_ovf = 0, out_en = 0, in_pop = 0, all asynchronously and irrespective of other inputs.
REQ-027 Normal operation SHALL resume on the first rising clk after reset returns to 1.
REQ-028 Reset asserted mid-transfer SHALL discard in-flight credit state; no pending return is remembered.

Verification
REQ-029 Unicast: sel[E]=W, sel_vld[E]=1, push_o[W]=1 held 4 cycles, no returns -> out_en[E]=1 and in_pop[W]=1 for 4 cycles; credit_cnt[E] goes 4,3,2,1,0; cycle 5 gives out_en[E]=0 and in_pop[W]=0.
REQ-030 Multicast: outputs N and S both select input L with credit_cnt[N]=0 and credit_cnt[S]=4 -> out_en[N]=0, out_en[S]=0, in_pop[L]=0; one credit_ret[N] -> next cycle both enables and in_pop[L] are 1.
REQ-031 Simultaneous: credit_cnt[E]=2, out_en[E]=1 and credit_ret[E]=1 in the same cycle -> credit_cnt[E] stays 2.
REQ-032 Overflow: credit_cnt[W]=4, credit_ret[W]=1 -> count stays 4, err_ovf[W]=1, and it remains 1 after 10 idle cycles.
REQ-033 Invalid select: sel slice = 7 with sel_vld=1 and every push_o=1 -> that output's out_en=0 and no in_pop is caused by it.
REQ-034 Reset mid-operation: after partial credit drain and err_ovf set, drive reset=0 asynchronously between clock edges -> all counts = 4 and all outputs = 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/out_en_alloc.sv
// Router output-enable allocator. Maps per-output select codes onto inputs and
// gates each unicast or multicast transfer on downstream credit.
module out_en_alloc_credit #(
  parameter int CREDITS = 4,
  parameter int CW      = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          ovf
);
  logic [CW-1:0] cnt_d, cnt_q;
  logic          ovf_d, ovf_q;

  // A return at full credit is dropped rather than wrapping; a same-cycle
  // send and return cancel out.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (inc && !dec) begin
      if (cnt_q == CW'(CREDITS)) ovf_d = 1'b1;
      else                       cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= CW'(CREDITS);
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;
endmodule

module out_en_alloc #(
  parameter int NUM_PORTS = 5,
  parameter int SEL_W     = 3,
  parameter int CREDITS   = 4,
  localparam int CW       = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PORTS*SEL_W-1:0] sel,
  input  logic [NUM_PORTS-1:0]       sel_vld,
  input  logic [NUM_PORTS-1:0]       push_o,
  input  logic [NUM_PORTS-1:0]       credit_ret,
  output logic [NUM_PORTS-1:0]       out_en,
  output logic [NUM_PORTS*CW-1:0]    credit_cnt,
  output logic [NUM_PORTS-1:0]       in_pop,
  output logic [NUM_PORTS-1:0]       err_ovf
);
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req;   // [output][input]
  logic [NUM_PORTS-1:0][CW-1:0]        cnt;
  logic [NUM_PORTS-1:0]                any_req, blocked, elig;

  always_comb begin
    req = '0;
    for (int o = 0; o < NUM_PORTS; o++)
      for (int i = 0; i < NUM_PORTS; i++)
        req[o][i] = sel_vld[o] && (sel[o*SEL_W +: SEL_W] == SEL_W'(i));
  end

  // One empty requester blocks the whole multicast so it stays atomic.
  always_comb begin
    any_req = '0;
    blocked = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      for (int o = 0; o < NUM_PORTS; o++) begin
        any_req[i] = any_req[i] | req[o][i];
        blocked[i] = blocked[i] | (req[o][i] && (cnt[o] == '0));
      end
  end

  always_comb begin
    elig   = '0;
    out_en = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      elig[i] = reset && push_o[i] && any_req[i] && !blocked[i];
    for (int o = 0; o < NUM_PORTS; o++)
      out_en[o] = reset && |(req[o] & elig);
  end

  assign in_pop     = elig;
  assign credit_cnt = cnt;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cred
    out_en_alloc_credit #(.CREDITS(CREDITS), .CW(CW)) u_cred (
      .clk   (clk),
      .reset (reset),
      .dec   (out_en[g]),
      .inc   (credit_ret[g]),
      .cnt   (cnt[g]),
      .ovf   (err_ovf[g])
    );
  end
endmodule

// File: tb/tb_out_en_alloc.sv
// Directed bench for out_en_alloc: unicast drain, atomic multicast, credit
// cancel/overflow, invalid selects and asynchronous reset.
module tb_out_en_alloc;
  localparam int NP = 5, SW = 3, CW = 4;
  localparam int PN = 0, PE = 1, PS = 2, PW = 3, PL = 4;

  logic            clk = 1'b0, reset = 1'b0;
  logic [NP*SW-1:0] sel = '0;
  logic [NP-1:0]   sel_vld = '0, push_o = '0, credit_ret = '0;
  logic [NP-1:0]   out_en, in_pop, err_ovf;
  logic [NP*CW-1:0] credit_cnt;
  int checks = 0, errors = 0;

  out_en_alloc #(.NUM_PORTS(NP), .SEL_W(SW), .CREDITS(4)) dut (
    .clk(clk), .reset(reset), .sel(sel), .sel_vld(sel_vld), .push_o(push_o),
    .credit_ret(credit_ret), .out_en(out_en), .credit_cnt(credit_cnt),
    .in_pop(in_pop), .err_ovf(err_ovf));

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] cnt_of(input int o);
    return credit_cnt[o*CW +: CW];
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    sel = '0; sel_vld = '0; push_o = '0; credit_ret = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    sel = {3'(PL), 3'(PL), 3'(PL), 3'(PL), 3'(PL)};
    sel_vld = '1; push_o = '1; credit_ret = '1;
    @(negedge clk); #1;
    checks++;
    if (credit_cnt !== {NP{4'd4}}) begin errors++; $display("FAIL reset_cnt got %h want %h", credit_cnt, {NP{4'd4}}); end
    checks++;
    if (out_en !== '0 || in_pop !== '0 || err_ovf !== '0) begin
      errors++; $display("FAIL reset_outs out_en=%b in_pop=%b err=%b want 0", out_en, in_pop, err_ovf);
    end
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_unicast();
    do_reset();
    sel[PE*SW +: SW] = 3'(PW); sel_vld[PE] = 1'b1; push_o[PW] = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_en !== 5'b00010 || in_pop !== 5'b01000 || cnt_of(PE) !== 4'(4-k)) begin
        errors++;
        $display("FAIL unicast_c%0d out_en=%b in_pop=%b cnt=%0d want 00010 01000 %0d",
                 k, out_en, in_pop, cnt_of(PE), 4-k);
      end
      step(); #1;
    end
    checks++;
    if (out_en !== '0 || in_pop !== '0 || cnt_of(PE) !== 4'd0) begin
      errors++; $display("FAIL unicast_empty out_en=%b in_pop=%b cnt=%0d want 0 0 0", out_en, in_pop, cnt_of(PE));
    end
  endtask

  task automatic test_multicast();
    do_reset();
    sel[PN*SW +: SW] = 3'(PL); sel_vld[PN] = 1'b1; push_o[PL] = 1'b1;
    repeat (4) step();
    sel[PS*SW +: SW] = 3'(PL); sel_vld[PS] = 1'b1;
    #1;
    checks++;
    if (cnt_of(PN) !== 4'd0 || cnt_of(PS) !== 4'd4 || out_en !== '0 || in_pop !== '0) begin
      errors++; $display("FAIL mcast_blocked cntN=%0d cntS=%0d out_en=%b in_pop=%b want 0 4 0 0",
                         cnt_of(PN), cnt_of(PS), out_en, in_pop);
    end
    credit_ret[PN] = 1'b1;
    #1;
    checks++;
    if (out_en !== '0 || in_pop !== '0) begin
      errors++; $display("FAIL mcast_ret_cycle out_en=%b in_pop=%b want 0 0", out_en, in_pop);
    end
    step();
    credit_ret = '0;
    #1;
    checks++;
    if (out_en !== 5'b00101 || in_pop !== 5'b10000) begin
      errors++; $display("FAIL mcast_grant out_en=%b in_pop=%b want 00101 10000", out_en, in_pop);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (cnt_of(PN) !== 4'd0 || cnt_of(PS) !== 4'd3) begin
      errors++; $display("FAIL mcast_cnt cntN=%0d cntS=%0d want 0 3", cnt_of(PN), cnt_of(PS));
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    sel[PE*SW +: SW] = 3'(PW); sel_vld[PE] = 1'b1; push_o[PW] = 1'b1;
    repeat (2) step();
    credit_ret[PE] = 1'b1;
    #1;
    checks++;
    if (out_en !== 5'b00010 || cnt_of(PE) !== 4'd2) begin
      errors++; $display("FAIL simul_pre out_en=%b cnt=%0d want 00010 2", out_en, cnt_of(PE));
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (cnt_of(PE) !== 4'd2) begin errors++; $display("FAIL simul_hold cnt=%0d want 2", cnt_of(PE)); end
  endtask

  task automatic test_overflow();
    do_reset();
    credit_ret[PW] = 1'b1;
    step();
    credit_ret = '0;
    #1;
    checks++;
    if (cnt_of(PW) !== 4'd4 || err_ovf !== 5'b01000) begin
      errors++; $display("FAIL ovf_set cnt=%0d err=%b want 4 01000", cnt_of(PW), err_ovf);
    end
    repeat (10) step();
    #1;
    checks++;
    if (cnt_of(PW) !== 4'd4 || err_ovf !== 5'b01000) begin
      errors++; $display("FAIL ovf_sticky cnt=%0d err=%b want 4 01000", cnt_of(PW), err_ovf);
    end
  endtask

  task automatic test_invalid_sel();
    do_reset();
    push_o = '1;
    sel[PN*SW +: SW] = 3'd7; sel_vld[PN] = 1'b1;
    #1;
    checks++;
    if (out_en !== '0 || in_pop !== '0) begin
      errors++; $display("FAIL inval_7 out_en=%b in_pop=%b want 0 0", out_en, in_pop);
    end
    sel[PN*SW +: SW] = 3'd5;
    sel[PS*SW +: SW] = 3'(PL); sel_vld[PS] = 1'b1;
    #1;
    checks++;
    if (out_en !== 5'b00100 || in_pop !== 5'b10000) begin
      errors++; $display("FAIL inval_5 out_en=%b in_pop=%b want 00100 10000", out_en, in_pop);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (cnt_of(PN) !== 4'd4 || cnt_of(PS) !== 4'd3) begin
      errors++; $display("FAIL inval_cnt cntN=%0d cntS=%0d want 4 3", cnt_of(PN), cnt_of(PS));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    sel[PE*SW +: SW] = 3'(PW); sel_vld[PE] = 1'b1; push_o[PW] = 1'b1;
    credit_ret[PW] = 1'b1;
    repeat (2) step();
    credit_ret = '0;
    #1;
    checks++;
    if (cnt_of(PE) !== 4'd2 || err_ovf !== 5'b01000 || out_en !== 5'b00010) begin
      errors++; $display("FAIL mid_pre cnt=%0d err=%b out_en=%b want 2 01000 00010", cnt_of(PE), err_ovf, out_en);
    end
    credit_ret[PE] = 1'b1;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (credit_cnt !== {NP{4'd4}} || out_en !== '0 || in_pop !== '0 || err_ovf !== '0) begin
      errors++; $display("FAIL mid_async cnt=%h out_en=%b in_pop=%b err=%b want 44444 0 0 0",
                         credit_cnt, out_en, in_pop, err_ovf);
    end
    step();
    credit_ret = '0;
    reset = 1'b1;
    #1;
    checks++;
    if (cnt_of(PE) !== 4'd4 || out_en !== 5'b00010 || in_pop !== 5'b01000) begin
      errors++; $display("FAIL mid_resume cnt=%0d out_en=%b in_pop=%b want 4 00010 01000", cnt_of(PE), out_en, in_pop);
    end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_multicast();
    test_simultaneous();
    test_overflow();
    test_invalid_sel();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
